// File: rtl/sq_pkg.sv
// Shared types and constants for the squaring operand sequencer and its downstream users.
package sq_pkg;

  localparam int unsigned NUM_LIMBS  = 129;
  localparam int unsigned LIMB_W     = 17;
  localparam int unsigned NUM_PHASES = 10;

  typedef logic [4:0]            sq_state_t;
  typedef logic [LIMB_W-1:0]     limb_t;
  typedef limb_t [NUM_LIMBS-1:0] op_t;

  localparam sq_state_t SQ_IDLE = 5'd0;
  localparam sq_state_t SQ_LAST = sq_state_t'(NUM_PHASES);

endpackage

// File: rtl/sq_seq_if.sv
// Start handshake, held operand and phase-tag outputs of the squaring sequencer.
interface sq_seq_if;
  import sq_pkg::*;

  logic      start_i;
  op_t       op_i;
  logic      ready_o;
  sq_state_t SQ_STATE;
  op_t       curr_op;
  logic      prod_valid_o;
  sq_state_t prod_state_o;
  logic      done_o;
  logic      busy_o;

  modport master (
    output start_i, op_i,
    input  ready_o, SQ_STATE, curr_op, prod_valid_o, prod_state_o, done_o, busy_o
  );

  modport slave (
    input  start_i, op_i,
    output ready_o, SQ_STATE, curr_op, prod_valid_o, prod_state_o, done_o, busy_o
  );

endinterface

// File: rtl/sq_tag_pipe.sv
// Depth-stage shift register of phase tags, aligning SQ_STATE with multiplier output.
module sq_tag_pipe
  import sq_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic      clk,
  input  logic      reset,
  input  sq_state_t tag_i,
  output sq_state_t tag_o,
  output logic      any_o
);

  sq_state_t stage_q [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) stage_q[i] <= SQ_IDLE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Any non-idle tag still in flight keeps the pass alive.
  always_comb begin
    any_o = 1'b0;
    for (int i = 0; i < int'(Depth); i++) any_o = any_o | (stage_q[i] != SQ_IDLE);
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/sq_seq.sv
// Squaring operand holder and phase sequencer. Define SQ_PIPE_OVERLAP_EN to allow a new
// start in the last phase, so back-to-back passes run with no idle bubble.
module sq_seq
  import sq_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input logic    clk,
  input logic    reset,
  sq_seq_if.slave bus
);

  sq_state_t state_q;
  op_t       op_q;
  sq_state_t tag_out;
  logic      tags_busy;
  logic      busy;
  logic      ready;
  logic      accept;

  assign busy = (state_q != SQ_IDLE) | tags_busy;

`ifdef SQ_PIPE_OVERLAP_EN
  assign ready = ((state_q == SQ_IDLE) & ~busy) | (state_q == SQ_LAST);
`else
  assign ready = (state_q == SQ_IDLE) & ~busy;
`endif

  assign accept = bus.start_i & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SQ_IDLE;
      op_q    <= '0;
    end else begin
      if (accept) begin
        op_q    <= bus.op_i;
        state_q <= 5'd1;
      end else if (state_q == SQ_IDLE || state_q >= SQ_LAST) begin
        // Also scrubs any out-of-range value back to idle.
        state_q <= SQ_IDLE;
      end else begin
        state_q <= state_q + 5'd1;
      end
    end
  end

  sq_tag_pipe #(
    .Depth (MUL_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (state_q),
    .tag_o (tag_out),
    .any_o (tags_busy)
  );

  assign bus.ready_o      = ready;
  assign bus.SQ_STATE     = state_q;
  assign bus.curr_op      = op_q;
  assign bus.prod_state_o = tag_out;
  assign bus.prod_valid_o = (tag_out != SQ_IDLE);
  assign bus.done_o       = (tag_out == SQ_LAST);
  assign bus.busy_o       = busy;

endmodule

// File: tb/tb_sq_seq.sv
// Directed self-checking bench for sq_seq with MUL_LAT = 3.
module tb_sq_seq;
  import sq_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sq_seq_if bus ();

  sq_seq #(
    .MUL_LAT (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int base);
    for (int k = 0; k < int'(NUM_LIMBS); k++) bus.op_i[k] = limb_t'(base + k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    int first_done;
    int second_done;
    int waited;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.start_i = 1'b0;
    set_op(0);
    step();
    step();
    reset = 1'b0;

    // Idle after reset release.
    for (int c = 0; c < 5; c++) begin
      check("idle_state", 32'(bus.SQ_STATE), 0);
      check("idle_ready", 32'(bus.ready_o), 1);
      check("idle_busy", 32'(bus.busy_o), 0);
      check("idle_pvalid", 32'(bus.prod_valid_o), 0);
      check("idle_done", 32'(bus.done_o), 0);
      step();
    end

    // Single pass, limb k = k; op_i scrambled afterwards to prove it is held.
    set_op(0);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    set_op(1000);
    for (int c = 1; c <= 14; c++) begin
      check("p1_state", 32'(bus.SQ_STATE), (c <= 10) ? c : 0);
      check("p1_op128", 32'(bus.curr_op[128]), 128);
      check("p1_op64", 32'(bus.curr_op[64]), 64);
      check("p1_pstate", 32'(bus.prod_state_o), (c >= 4 && c <= 13) ? c - 3 : 0);
      check("p1_pvalid", 32'(bus.prod_valid_o), (c >= 4 && c <= 13) ? 1 : 0);
      check("p1_done", 32'(bus.done_o), (c == 13) ? 1 : 0);
      check("p1_busy", 32'(bus.busy_o), (c <= 13) ? 1 : 0);
      check("p1_ready", 32'(bus.ready_o), (c == 14) ? 1 : 0);
      if (c < 14) step();
    end
    step();

    // Start held high mid-pass with a different operand must be ignored.
    set_op(1);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 16; c++) begin
      if (bus.done_o) ndone++;
      if (c == 5) begin
        bus.start_i = 1'b1;
        for (int k = 0; k < int'(NUM_LIMBS); k++) bus.op_i[k] = 17'h1abcd;
      end
      if (c == 6) check("ign_state", 32'(bus.SQ_STATE), 6);
      if (c == 9) check("ign_op0", 32'(bus.curr_op[0]), 1);
      if (c == 10) bus.start_i = 1'b0;
      if (c == 10) check("ign_op128", 32'(bus.curr_op[128]), 129);
      step();
    end
    check("ign_ndone", 32'(ndone), 1);

    // Asynchronous reset in the middle of a pass.
    set_op(7);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int c = 1; c < 6; c++) step();
    check("rst_pre_state", 32'(bus.SQ_STATE), 6);
    check("rst_pre_pstate", 32'(bus.prod_state_o), 3);
    #2;
    reset = 1'b1;
    #1;
    check("rst_state", 32'(bus.SQ_STATE), 0);
    check("rst_op", 32'(bus.curr_op[5]), 0);
    check("rst_pstate", 32'(bus.prod_state_o), 0);
    check("rst_pvalid", 32'(bus.prod_valid_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    step();
    step();
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done_o) ndone++;
      step();
    end
    check("rst_ndone", 32'(ndone), 0);
    check("rst_ready", 32'(bus.ready_o), 1);

`ifdef SQ_PIPE_OVERLAP_EN
    // Back-to-back passes: second start in the LAST cycle.
    set_op(0);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    ndone = 0;
    first_done = 0;
    second_done = 0;
    for (int c = 1; c <= 30; c++) begin
      if (bus.done_o) begin
        ndone++;
        if (ndone == 1) first_done = c;
        if (ndone == 2) second_done = c;
      end
      if (c == 10) begin
        check("ov_state10", 32'(bus.SQ_STATE), 10);
        check("ov_ready10", 32'(bus.ready_o), 1);
        check("ov_op_old", 32'(bus.curr_op[0]), 0);
        bus.start_i = 1'b1;
        set_op(256);
      end
      if (c == 11) begin
        bus.start_i = 1'b0;
        check("ov_state11", 32'(bus.SQ_STATE), 1);
        check("ov_op_new", 32'(bus.curr_op[0]), 256);
        check("ov_busy", 32'(bus.busy_o), 1);
      end
      step();
    end
    check("ov_ndone", 32'(ndone), 2);
    check("ov_first", 32'(first_done), 13);
    check("ov_second", 32'(second_done), 23);
`else
    // Start in the LAST cycle is ignored; next accept only once busy_o falls.
    set_op(0);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 10) begin
        check("nov_state10", 32'(bus.SQ_STATE), 10);
        check("nov_ready10", 32'(bus.ready_o), 0);
        bus.start_i = 1'b1;
        set_op(300);
      end
      if (c >= 11 && c <= 14) check("nov_ignored", 32'(bus.SQ_STATE), 0);
      if (c == 12) check("nov_op_held", 32'(bus.curr_op[0]), 0);
      if (c == 13) check("nov_ready13", 32'(bus.ready_o), 0);
      if (c == 14) check("nov_ready14", 32'(bus.ready_o), 1);
      if (c == 15) begin
        check("nov_accept", 32'(bus.SQ_STATE), 1);
        check("nov_op_new", 32'(bus.curr_op[0]), 300);
        bus.start_i = 1'b0;
      end
      if (c < 15) step();
    end
    waited = 0;
    while (bus.busy_o && waited < 40) begin
      step();
      waited++;
    end
    check("nov_drain", 32'(bus.busy_o), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sq_seq.md
Name: sq_seq

Overview:
- Operand-holding and sequencing stage directly upstream of the squaring multiplier-slice mux (curr_mul).
- Latches a 129-limb x 17-bit operand on a start handshake and holds it stable as curr_op.
- Steps SQ_STATE through the 10 partial-product phases, 1..10, one per cycle.
- Runs a tag delay line matched to the multiplier pipeline, so the downstream accumulator knows which phase's products are emerging and when the square is complete.

Parameters:
- NUM_LIMBS, 129, limbs in operand (4 x 32 + 1).
- LIMB_W, 17, bits per limb.
- NUM_PHASES, 10, last SQ_STATE value of a squaring pass.
- MUL_LAT, 3, multiplier pipeline latency in cycles (>= 1), from SQ_STATE to product availability.

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- start_i, input, 1, request to begin a squaring pass with op_i.
- op_i, input, [NUM_LIMBS-1:0][LIMB_W-1:0], operand to square; sampled only on accepted start.
- ready_o, output, 1, start_i is accepted this cycle when high.
- SQ_STATE, output, 5, current phase; 0 = idle.
- curr_op, output, [NUM_LIMBS-1:0][LIMB_W-1:0], registered operand feeding the multiplier mux.
- prod_valid_o, output, 1, multiplier outputs this cycle belong to phase prod_state_o.
- prod_state_o, output, 5, phase tag delayed by MUL_LAT; 0 when invalid.
- done_o, output, 1, one-cycle pulse with the phase-NUM_PHASES products.
- busy_o, output, 1, a pass is in progress (SQ_STATE != 0 or tags in flight).

Behaviour:
- Reset (asynchronous, any time including mid-pass) clears everything immediately:
  - SQ_STATE = 0, curr_op = 0, all delay-line tags = 0.
  - prod_valid_o = 0, prod_state_o = 0, done_o = 0, busy_o = 0, ready_o = 1 after release.
- State machine is SQ_STATE itself:
  - IDLE (0): on start_i & ready_o, curr_op <= op_i and SQ_STATE <= 1 at the next edge.
  - RUN (1..NUM_PHASES-1): SQ_STATE increments by 1 each cycle unconditionally; no stall input.
  - LAST (NUM_PHASES): next SQ_STATE = 0. Exception: an accepted start with SQ_PIPE_OVERLAP_EN moves it to 1.
- curr_op changes only on an accepted start edge. It is stable for all NUM_PHASES cycles of a pass.
- ready_o (base build) = (SQ_STATE == 0) & ~busy_o.
  - Start requests with ready_o low are ignored and not queued.
- Tag delay line: MUL_LAT registers. Stage 0 captures SQ_STATE each cycle; each stage shifts forward.
  - prod_state_o = last stage.
  - prod_valid_o = (prod_state_o != 0).
  - done_o = (prod_state_o == NUM_PHASES).
- Latency: start accepted at edge T → SQ_STATE = 1 during cycle T+1.
  - prod_state_o = 1 during cycle T+1+MUL_LAT.
  - done_o during cycle T+NUM_PHASES+MUL_LAT.
- busy_o = (SQ_STATE != 0) | (any delay-line stage != 0).
- SQ_STATE never takes values above NUM_PHASES. Illegal values (e.g. upset) return to 0 on the next edge.

Optional Feature:
- Macro: SQ_PIPE_OVERLAP_EN.
- Defined: ready_o = (SQ_STATE == 0 & ~busy_o) | (SQ_STATE == NUM_PHASES).
  - A start accepted in the LAST cycle loads the new op and goes to SQ_STATE 1 with no idle bubble.
  - The old pass's tags continue draining.
  - done_o pulses once per pass.
  - busy_o stays high across back-to-back passes.
- Undefined: ready_o as in base. At least MUL_LAT+1 idle cycles separate passes.

Decomposition:
- Shared package sq_pkg:
  - NUM_LIMBS, LIMB_W, NUM_PHASES constants.
  - sq_state_t (logic [4:0]) with named values SQ_IDLE = 0, SQ_LAST = 10.
  - limb_t and op_t typedefs.
  - curr_mul is retyped to these in a follow-up.
- One sub-module: sq_tag_pipe (parameterised MUL_LAT-deep shift register of sq_state_t with async reset). Reused by the downstream accumulator for its own alignment.

Test Plan:
- Reset release, idle 5 cycles → SQ_STATE = 0, ready_o = 1, busy_o = 0, prod_valid_o = 0, done_o never asserted.
- start_i for one cycle with op_i limbs = index (limb k = k) at edge T:
  - SQ_STATE = 1..10 in cycles T+1..T+10, then 0.
  - curr_op[128] = 128 throughout.
  - prod_state_o = 1..10 in cycles T+4..T+13; done_o only at T+13 (MUL_LAT = 3).
- start_i held high with a different op_i while SQ_STATE = 5 → ignored; curr_op unchanged; single done_o pulse.
- reset asserted asynchronously mid-pass (SQ_STATE = 6, tags in flight) → all outputs 0 immediately; no done_o after release.
- SQ_PIPE_OVERLAP_EN, second start in the cycle SQ_STATE = 10:
  - SQ_STATE goes 10 → 1 with no 0 cycle.
  - curr_op switches at that edge.
  - Exactly two done_o pulses, 10 cycles apart.
- Non-overlap build, start in the cycle SQ_STATE = 10 → ignored; next accept only after busy_o falls.
